// File: rtl/md_sequencer_if.sv
// EX-stage / multiply-divide core signal bundle for md_sequencer.
// The slave modport is the sequencer's view; master is the surrounding pipeline/core.
interface md_sequencer_if;
   logic        ex_valid;
   logic        ex_flush;
   logic [2:0]  md_op;
   logic [1:0]  md_rd;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        core_done;
   logic [31:0] core_hi;
   logic [31:0] core_lo;
   logic        core_start;
   logic        core_isdiv;
   logic        core_sign;
   logic [31:0] core_a;
   logic [31:0] core_b;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        ex_stall;
   logic        busy;
   logic        md_err;

   modport slave (
      input  ex_valid, ex_flush, md_op, md_rd, op_a, op_b,
             core_done, core_hi, core_lo,
      output core_start, core_isdiv, core_sign, core_a, core_b,
             hi, lo, ex_stall, busy, md_err
   );

   modport master (
      output ex_valid, ex_flush, md_op, md_rd, op_a, op_b,
             core_done, core_hi, core_lo,
      input  core_start, core_isdiv, core_sign, core_a, core_b,
             hi, lo, ex_stall, busy, md_err
   );
endinterface

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: launches the external MD core, owns HI/LO,
// stalls EX while the core is busy and aborts ops that exceed TIMEOUT cycles.
module md_sequencer #(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 7
) (
   input logic clk,
   input logic rst,
   md_sequencer_if.slave bus
);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             req;

   always_comb begin
      req = bus.ex_valid && (((bus.md_op != 3'd0) && (bus.md_op != 3'd7)) || (bus.md_rd != 2'b00));
      bus.ex_stall = req && (state != IDLE) && !bus.ex_flush;
   end

   assign bus.busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         cnt            <= '0;
         bus.core_start <= 1'b0;
         bus.core_isdiv <= 1'b0;
         bus.core_sign  <= 1'b0;
         bus.core_a     <= '0;
         bus.core_b     <= '0;
         bus.hi         <= '0;
         bus.lo         <= '0;
         bus.md_err     <= 1'b0;
      end else begin
         bus.core_start <= 1'b0;
         case (state)
            IDLE: begin
               // core_done is deliberately not looked at here
               if (bus.ex_valid && !bus.ex_flush) begin
                  case (bus.md_op)
                     3'd1, 3'd2, 3'd3, 3'd4: begin
                        bus.core_a     <= bus.op_a;
                        bus.core_b     <= bus.op_b;
                        bus.core_isdiv <= (bus.md_op == 3'd3) || (bus.md_op == 3'd4);
                        bus.core_sign  <= (bus.md_op == 3'd1) || (bus.md_op == 3'd3);
                        bus.core_start <= 1'b1;
                        cnt            <= '0;
                        state          <= WAIT;
                     end
                     3'd5:    bus.hi <= bus.op_a;
                     3'd6:    bus.lo <= bus.op_a;
                     default: ;
                  endcase
               end
            end
            WAIT: begin
               cnt <= cnt + 1'b1;
               if (bus.core_done) begin
                  bus.hi <= bus.core_hi;
                  bus.lo <= bus.core_lo;
                  state  <= IDLE;
               end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                  bus.md_err <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
